// File: rtl/wk_mac_accum.sv
// wk_mac_accum: multiplies TAPS samples by their Wk ROM weights and emits one 16-bit sum per frame.
// Build option WKMAC_SAT_EN: saturate the scaled result at 16'hFFFF instead of wrapping.
module wk_mac_accum #(
  parameter int TAPS  = 256,
  parameter int ACCW  = 24,
  parameter int SHIFT = 0
) (
  input  logic        CS,
  input  logic        cen,
  input  logic        start,
  input  logic        x_valid,
  input  logic [7:0]  x_in,
  output logic        x_ready,
  output logic [7:0]  add,
  input  logic [7:0]  Wkp,
  output logic [15:0] y_out,
  output logic        y_valid,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for start; accumulator result held on y_out
  // RUN   | accepting samples, issuing one ROM address per accept
  // DRAIN | no new samples; letting the two pipeline stages retire
  // DONE  | one cycle: latch scaled result and raise y_valid
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST_TAP = 8'(TAPS - 1);

  state_t          state_q;
  logic [7:0]      tap_cnt_q;
  logic [7:0]      add_q;
  logic [7:0]      s1_q;
  logic [7:0]      s2_q;
  logic            v1_q;
  logic            v2_q;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;
  logic [15:0]     y_out_q;
  logic            y_valid_q;
  logic [15:0]     prod;
  logic [15:0]     y_d;
  logic            accept;

  assign accept = (state_q == RUN) && x_valid;

  // s2 and Wkp line up: the ROM answers the address issued two edges before this one
  assign prod = {8'd0, s2_q} * {8'd0, Wkp};

  always_comb begin
    acc_d = acc_q;
    if (v2_q) begin
      acc_d = acc_q + {{(ACCW-16){1'b0}}, prod};
    end
  end

`ifdef WKMAC_SAT_EN
  logic [ACCW-1:0] acc_shr;
  assign acc_shr = acc_q >> SHIFT;
  assign y_d     = (|acc_shr[ACCW-1:16]) ? 16'hFFFF : acc_shr[15:0];
`else
  assign y_d = 16'(acc_q >> SHIFT);
`endif

  always_ff @(posedge CS) begin
    if (!cen) begin
      state_q   <= IDLE;
      tap_cnt_q <= 8'd0;
      add_q     <= 8'd0;
      s1_q      <= 8'd0;
      s2_q      <= 8'd0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      acc_q     <= '0;
      y_out_q   <= 16'd0;
      y_valid_q <= 1'b0;
    end else begin
      s2_q      <= s1_q;
      v2_q      <= v1_q;
      v1_q      <= 1'b0;
      acc_q     <= acc_d;
      y_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q     <= '0;
            tap_cnt_q <= 8'd0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          v1_q <= accept;
          if (accept) begin
            add_q     <= tap_cnt_q;
            s1_q      <= x_in;
            tap_cnt_q <= tap_cnt_q + 8'd1;
            if (tap_cnt_q == LAST_TAP) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!v1_q && !v2_q) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          y_out_q   <= y_d;
          y_valid_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_ready = (state_q == RUN);
  assign busy    = (state_q != IDLE);
  assign add     = add_q;
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_wk_mac_accum.sv
// Bench for wk_mac_accum: table-driven frames against a registered Wk ROM model, plus abort and back-to-back sequences.
module tb_wk_mac_accum;

  logic        CS = 1'b0;
  logic        cen = 1'b0;
  logic        start = 1'b0;
  logic        x_valid = 1'b0;
  logic [7:0]  x_in = 8'd0;
  logic        x_ready;
  logic [7:0]  add;
  logic [7:0]  Wkp = 8'd0;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  wk_mac_accum #(.TAPS(256), .ACCW(24), .SHIFT(0)) dut (
    .CS(CS), .cen(cen), .start(start), .x_valid(x_valid), .x_in(x_in),
    .x_ready(x_ready), .add(add), .Wkp(Wkp), .y_out(y_out),
    .y_valid(y_valid), .busy(busy)
  );

  always #5 CS = ~CS;
  always @(posedge CS) edge_n <= edge_n + 1;

  // ROM contents: weight 0 at address 0, weight 2 everywhere else; one-edge read latency
  always @(posedge CS) Wkp <= (add == 8'd0) ? 8'd0 : 8'd2;

`ifdef WKMAC_SAT_EN
  localparam int Y255 = 65535;
`else
  localparam int Y255 = 64514;
`endif

  typedef struct {
    logic [7:0] x;
    bit         toggle;
    bit         pulse;
    int         exp_y;
    int         exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] x, input bit toggle, input bit pulse,
                           input bit chain, input bit skip_start, input int exp_y,
                           input int exp_lat, input int exp_busy, input string tag);
    int  accepts, add_err, yv_cnt, start_edge, last_edge, yv_edge, y_seen, xr_last;
    bit  pend, ph;
    accepts = 0; add_err = 0; yv_cnt = 0; last_edge = -1; yv_edge = -1;
    y_seen = -1; xr_last = -1; ph = 1'b1;
    if (!skip_start) begin
      start = 1'b1;
      @(negedge CS);
    end
    start = 1'b0;
    start_edge = edge_n;
    x_in = x;
    for (int c = 0; c < 1500; c++) begin
      x_valid = (accepts < 256) && (toggle ? ph : 1'b1);
      ph = !ph;
      start = (pulse && (c == 30 || (last_edge >= 0 && edge_n == last_edge)))
              || (chain && yv_edge >= 0);
      pend = x_valid && x_ready;
      @(negedge CS);
      if (pend) begin
        if (add !== accepts[7:0]) add_err++;
        accepts++;
        if (accepts == 256) begin
          last_edge = edge_n;
          xr_last = int'(x_ready);
        end
      end
      if (y_valid) begin
        yv_cnt++;
        if (yv_edge < 0) begin
          yv_edge = edge_n;
          y_seen = int'(y_out);
        end
      end
      if (yv_edge >= 0 && edge_n == yv_edge + 1) break;
    end
    x_valid = 1'b0;
    if (!chain) start = 1'b0;
    chk({tag, " accepts"}, accepts, 256);
    chk({tag, " add_sequence_errors"}, add_err, 0);
    chk({tag, " x_ready_after_last"}, xr_last, 0);
    chk({tag, " y_out"}, y_seen, exp_y);
    chk({tag, " y_valid_cycles"}, yv_cnt, 1);
    chk({tag, " last_accept_to_y_valid"}, yv_edge - last_edge, 4);
    chk({tag, " start_to_y_valid"}, yv_edge - start_edge, exp_lat);
    chk({tag, " busy_after"}, int'(busy), exp_busy);
  endtask

  initial begin
    int yv_abort;
    int accepts;
    bit pend;

    vecs[0] = '{x: 8'd1,   toggle: 1'b0, pulse: 1'b0, exp_y: 510,   exp_lat: 260};
    vecs[1] = '{x: 8'd255, toggle: 1'b0, pulse: 1'b0, exp_y: Y255,  exp_lat: 260};
    vecs[2] = '{x: 8'd100, toggle: 1'b1, pulse: 1'b0, exp_y: 51000, exp_lat: 515};
    vecs[3] = '{x: 8'd1,   toggle: 1'b0, pulse: 1'b1, exp_y: 510,   exp_lat: 260};

    cen = 1'b0;
    repeat (3) @(negedge CS);
    cen = 1'b1;
    chk("reset y_out", int'(y_out), 0);
    chk("reset y_valid", int'(y_valid), 0);
    chk("reset x_ready", int'(x_ready), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset add", int'(add), 0);
    @(negedge CS);

    foreach (vecs[i]) begin
      run_frame(vecs[i].x, vecs[i].toggle, vecs[i].pulse, 1'b0, 1'b0,
                vecs[i].exp_y, vecs[i].exp_lat, 0, $sformatf("vec%0d", i));
      repeat (2) @(negedge CS);
    end

    // abort mid-frame at tap 100
    x_in = 8'd1;
    start = 1'b1;
    @(negedge CS);
    start = 1'b0;
    accepts = 0;
    for (int c = 0; c < 400 && accepts < 100; c++) begin
      x_valid = 1'b1;
      pend = x_valid && x_ready;
      @(negedge CS);
      if (pend) accepts++;
    end
    chk("abort reached_tap", accepts, 100);
    cen = 1'b0;
    x_valid = 1'b0;
    @(negedge CS);
    cen = 1'b1;
    chk("abort y_out", int'(y_out), 0);
    chk("abort y_valid", int'(y_valid), 0);
    chk("abort x_ready", int'(x_ready), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort add", int'(add), 0);
    yv_abort = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge CS);
      if (y_valid) yv_abort++;
    end
    chk("abort no_y_valid", yv_abort, 0);
    run_frame(8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 510, 260, 0, "post_abort");
    repeat (2) @(negedge CS);

    // start in the y_valid cycle launches the next frame immediately
    run_frame(8'd255, 1'b0, 1'b0, 1'b1, 1'b0, Y255, 260, 1, "chain_first");
    run_frame(8'd1,   1'b0, 1'b0, 1'b0, 1'b1, 510,  260, 0, "chain_second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wk_mac_accum.md
Name: wk_mac_accum

Overview:
- Downstream consumer of the Wk weight ROM: drives its 8-bit address `add` and consumes its registered weight `Wkp`.
- Multiplies each incoming 8-bit speech/feature sample by the weight for its tap index and accumulates over a frame of TAPS samples.
- Emits one 16-bit neuron pre-activation per frame to the next classifier stage.

Parameters:
- TAPS, 256: samples per frame; tap index 0..TAPS-1 is driven on `add`; TAPS ≤ 256.
- ACCW, 24: accumulator width; must satisfy ACCW ≥ 16 + clog2(TAPS).
- SHIFT, 0: right-shift applied to the accumulator before output scaling.

Ports:
- CS  input  1: clock, rising edge; same clock that drives the Wk ROM.
- cen  input  1: reset; synchronous, active-low.
- start  input  1: one-cycle frame start request.
- x_valid  input  1: sample valid.
- x_in  input  8: unsigned sample.
- x_ready  output  1: sample accepted when x_valid && x_ready.
- add  output  8: registered ROM address.
- Wkp  input  8: unsigned weight from ROM, valid one CS edge after `add`.
- y_out  output  16: frame result.
- y_valid  output  1: one-cycle result strobe.
- busy  output  1: high in any state other than IDLE.

Behaviour:
- Reset (cen=0 at a CS edge) sets:
  - state=IDLE, tap_cnt=0, acc=0, add=0.
  - Pipeline valids v1=v2=0, sample regs s1=s2=0.
  - y_out=0, y_valid=0, x_ready=0, busy=0.
  - Reset mid-frame aborts the frame with no y_valid, and takes priority over every other input.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - x_ready=0.
  - start=1 → acc<=0, tap_cnt<=0, go to RUN.
  - start seen in any other state is ignored.
- RUN:
  - x_ready=1.
  - On accept: add<=tap_cnt, s1<=x_in, v1<=1, tap_cnt<=tap_cnt+1.
  - No accept: v1<=0. A stall is a pipeline bubble with no accumulate.
  - Accept with tap_cnt==TAPS-1 → go to DRAIN; x_ready drops the following cycle.
- Pipeline, every cycle in any non-reset state:
  - s2<=s1, v2<=v1.
  - If v2: acc <= acc + s2*Wkp. This is an unsigned 8x8 multiply giving a 16-bit product, zero-extended to ACCW.
  - Wkp at that edge is the ROM response to the `add` issued two edges earlier.
- DRAIN:
  - v1<=0.
  - Leave for DONE when v1==0 and v2==0, i.e. after exactly 2 cycles.
- DONE (one cycle):
  - y_out <= scale(acc >> SHIFT), y_valid<=1 for the next cycle only, go to IDLE.
  - y_out holds its value until the next DONE or reset.
- Latency: y_valid is high for the single cycle following the 4th CS edge after the edge that accepted the final sample.
  - Continuous x_valid gives TAPS+4 cycles from the start-accepting edge to y_valid.
- start is accepted in the IDLE cycle in which y_valid is high.
- add holds its last value outside RUN.
- Overflow: acc cannot overflow given the ACCW rule. Only output scaling can overflow (see Optional Feature).

Optional Feature:
- Macro: WKMAC_SAT_EN.
- Defined: scale() saturates; any value > 16'hFFFF outputs 16'hFFFF.
- Undefined: scale() truncates to the low 16 bits (wrap).

Test Plan:
- Current ROM contents: weight 0 at address 0, 2 elsewhere. TAPS=256, SHIFT=0.
- Reset, then start with x_in=1 every cycle, x_valid held high:
  - add sequences 0..255.
  - y_out=510.
  - y_valid exactly one cycle, 260 cycles after start accepted.
  - busy low afterwards.
- x_in=255 continuous:
  - With WKMAC_SAT_EN: y_out=16'hFFFF.
  - Without: y_out=64514 (130050 mod 65536).
- x_in=100 with x_valid toggling 1/0 each cycle:
  - y_out=51000.
  - y_valid appears 4 CS edges after the 256th accept.
  - No accumulate on bubble cycles.
- Pulse start again during RUN and DRAIN:
  - No restart.
  - Frame result unchanged (510 with x_in=1).
- Drive cen=0 at tap 100:
  - All outputs return to reset values.
  - No y_valid.
  - A following start with x_in=1 yields y_out=510.
- start in the same cycle y_valid is high:
  - New frame begins.
  - Second y_out is correct (510) and independent of the first frame's acc.
